// File: rtl/arm_multicycle_ctrl.sv
// Multicycle ARM control unit: main FSM, registered NZCV flags, condition check and ALU decode.
// Defining CTRL_PERF_CNT_EN adds RetiredCount/SkippedCount instruction counters.
module arm_multicycle_ctrl #(
   parameter int unsigned MEM_LAT   = 1,
   parameter logic [3:0]  FLAGS_RST = 4'b0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [3:0]  Cond,
   input  logic [1:0]  Op,
   input  logic [5:0]  Funct,
   input  logic [3:0]  Rd,
   input  logic [3:0]  ALUFlags,
   output logic        PCWrite,
   output logic        AdrSrc,
   output logic        MemWrite,
   output logic        IRWrite,
   output logic [1:0]  ResultSrc,
   output logic        ALUSrcA,
   output logic [1:0]  ALUSrcB,
   output logic [1:0]  ImmSrc,
   output logic [1:0]  RegSrc,
   output logic        RegWrite,
   output logic        LinkWrite,
   output logic [2:0]  ALUControl,
   output logic [3:0]  Flags,
`ifdef CTRL_PERF_CNT_EN
   output logic [31:0] RetiredCount,
   output logic [31:0] SkippedCount,
`endif
   output logic        Undef
);

   typedef enum logic [3:0] {
      S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB,
      S_MEMWR, S_EXECR, S_EXECI, S_ALUWB, S_BRANCH
   } state_t;

   localparam logic [3:0] CNT_LAST = 4'(MEM_LAT - 1);

   state_t     state_q, state_d;
   logic [3:0] cnt_q;
   logic [3:0] flags_q;
   logic       condex_q;
   logic       cond_ex, mem_done, rd_pc;
   logic       f_n, f_z, f_c, f_v;
   logic [2:0] dp_aluc;
   logic       dp_arith, dp_s, dp_wb, dp_undef;

   assign mem_done = (cnt_q == CNT_LAST);
   assign rd_pc    = (Rd == 4'hF);
   assign Flags    = flags_q;
   assign {f_n, f_z, f_c, f_v} = flags_q;

   always_comb begin
      cond_ex = 1'b0;
      unique case (Cond)
         4'b0000: cond_ex = f_z;
         4'b0001: cond_ex = !f_z;
         4'b0010: cond_ex = f_c;
         4'b0011: cond_ex = !f_c;
         4'b0100: cond_ex = f_n;
         4'b0101: cond_ex = !f_n;
         4'b0110: cond_ex = f_v;
         4'b0111: cond_ex = !f_v;
         4'b1000: cond_ex = f_c && !f_z;
         4'b1001: cond_ex = !f_c || f_z;
         4'b1010: cond_ex = (f_n == f_v);
         4'b1011: cond_ex = (f_n != f_v);
         4'b1100: cond_ex = !f_z && (f_n == f_v);
         4'b1101: cond_ex = f_z || (f_n != f_v);
         4'b1110: cond_ex = 1'b1;
         4'b1111: cond_ex = 1'b0;
      endcase
   end

   // CMP behaves as a flag-setting SUB that never writes back.
   always_comb begin
      dp_aluc  = 3'b000;
      dp_arith = 1'b0;
      dp_wb    = 1'b1;
      dp_undef = 1'b0;
      unique case (Funct[4:1])
         4'b0100: begin dp_aluc = 3'b000; dp_arith = 1'b1; end
         4'b0010: begin dp_aluc = 3'b001; dp_arith = 1'b1; end
         4'b0000: dp_aluc = 3'b010;
         4'b1100: dp_aluc = 3'b011;
         4'b1101: dp_aluc = 3'b100;
         4'b1010: begin dp_aluc = 3'b001; dp_arith = 1'b1; dp_wb = 1'b0; end
         default: begin dp_undef = 1'b1; dp_wb = 1'b0; end
      endcase
      dp_s = Funct[0] || (Funct[4:1] == 4'b1010);
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_FETCH:  if (mem_done) state_d = S_DECODE;
         S_DECODE: begin
            if (!cond_ex) state_d = S_FETCH;
            else begin
               unique case (Op)
                  2'b00:   state_d = Funct[5] ? S_EXECI : S_EXECR;
                  2'b01:   state_d = S_MEMADR;
                  2'b10:   state_d = S_BRANCH;
                  default: state_d = S_FETCH;
               endcase
            end
         end
         S_MEMADR: state_d = Funct[0] ? S_MEMRD : S_MEMWR;
         S_MEMRD:  if (mem_done) state_d = S_MEMWB;
         S_MEMWR:  if (mem_done) state_d = S_FETCH;
         S_EXECR, S_EXECI: state_d = dp_wb ? S_ALUWB : S_FETCH;
         default:  state_d = S_FETCH;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= S_FETCH;
         cnt_q    <= 4'd0;
         flags_q  <= FLAGS_RST;
         condex_q <= 1'b0;
`ifdef CTRL_PERF_CNT_EN
         RetiredCount <= 32'd0;
         SkippedCount <= 32'd0;
`endif
      end else begin
         state_q <= state_d;
         // Non-dwell states change every cycle, so cnt only climbs in FETCH/MEMRD/MEMWR.
         cnt_q   <= (state_d != state_q) ? 4'd0 : cnt_q + 4'd1;
         if (state_q == S_DECODE) condex_q <= cond_ex;
         if ((state_q == S_EXECR || state_q == S_EXECI) && condex_q && !dp_undef && dp_s) begin
            flags_q[3:2] <= ALUFlags[3:2];
            if (dp_arith) flags_q[1:0] <= ALUFlags[1:0];
         end
`ifdef CTRL_PERF_CNT_EN
         if (state_d == S_FETCH && state_q != S_FETCH && state_q != S_DECODE)
            RetiredCount <= RetiredCount + 32'd1;
         if (state_q == S_DECODE && !cond_ex)
            SkippedCount <= SkippedCount + 32'd1;
`endif
      end
   end

   always_comb begin
      PCWrite    = 1'b0;
      AdrSrc     = 1'b0;
      MemWrite   = 1'b0;
      IRWrite    = 1'b0;
      ResultSrc  = 2'b00;
      ALUSrcA    = 1'b0;
      ALUSrcB    = 2'b00;
      ImmSrc     = 2'b00;
      RegSrc     = 2'b00;
      RegWrite   = 1'b0;
      LinkWrite  = 1'b0;
      ALUControl = 3'b000;
      Undef      = 1'b0;
      if (!reset) begin
         RegSrc = {Op == 2'b01, Op == 2'b10};
         unique case (state_q)
            S_FETCH: begin
               ALUSrcA = 1'b1; ALUSrcB = 2'b10; ResultSrc = 2'b10;
               IRWrite = mem_done; PCWrite = mem_done;
            end
            S_DECODE: begin
               ALUSrcA = 1'b1; ALUSrcB = 2'b10; ResultSrc = 2'b10;
               Undef   = cond_ex && (Op == 2'b11);
            end
            S_MEMADR: begin ALUSrcB = 2'b01; ImmSrc = 2'b01; end
            S_MEMRD:  AdrSrc = 1'b1;
            S_MEMWR:  begin AdrSrc = 1'b1; MemWrite = 1'b1; end
            S_MEMWB, S_ALUWB: begin
               ResultSrc = (state_q == S_MEMWB) ? 2'b01 : 2'b00;
               PCWrite   = rd_pc;
               RegWrite  = !rd_pc;
            end
            S_EXECR:  begin ALUControl = dp_aluc; Undef = dp_undef; end
            S_EXECI:  begin ALUSrcB = 2'b01; ALUControl = dp_aluc; Undef = dp_undef; end
            S_BRANCH: begin
               ALUSrcB = 2'b01; ImmSrc = 2'b10; ResultSrc = 2'b10;
               PCWrite = 1'b1;  LinkWrite = Funct[4];
            end
            default: ;
         endcase
      end
   end

endmodule
